// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: states, opcodes and datapath mux selects.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEMADR   = 4'd3,
      S_MEMRD    = 4'd4,
      S_MEMWB    = 4'd5,
      S_MEMWR    = 4'd6,
      S_RTYPE_EX = 4'd7,
      S_RTYPE_WB = 4'd8,
      S_BEQ_EX   = 4'd9,
      S_ADDI_EX  = 4'd10,
      S_IMM_WB   = 4'd11,
      S_JUMP     = 4'd12,
      S_LOGI_EX  = 4'd13
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] ALU_LOGIC = 2'b11;

   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

endpackage

// File: rtl/mips_mem_timeout.sv
// Memory wait watchdog: counts stalled cycles of the current access, sets sticky mem_err on the
// MEM_TIMEOUT-th cycle of an access (even if it completes then); never aborts the access.
module mips_mem_timeout #(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic mem_req,
   input  logic mem_ready,
   output logic mem_err
);

   localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT);

   logic [7:0] cnt_q, cnt_d;
   logic       err_q, err_d;

   // Counter is zero whenever an access starts, since every completion or non-memory cycle clears it.
   always_comb begin
      cnt_d = '0;
      err_d = err_q;
      if (mem_req) begin
         if (cnt_q == LIMIT - 8'd1)
            err_d = 1'b1;
         if (!mem_ready)
            cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign mem_err = err_q;

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM, one state per cycle, memory states stall on mem_ready.
// Define LOGIC_IMM_EN to decode andi/ori into a zero-extending logic-immediate path.
module mips_multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_write,
   output logic             iord,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic [1:0]       pc_src,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic             ext_op,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic             illegal,
   output logic             mem_err,
   output logic [CNT_W-1:0] instr_retired,
   output logic [3:0]       state
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             retire;

   always_comb begin
      state_d       = state_q;
      retire        = 1'b0;
      mem_req       = 1'b0;
      mem_write     = 1'b0;
      iord          = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_src        = PC_SRC_ALU;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_REG;
      alu_op        = ALU_ADD;
      ext_op        = 1'b1;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      illegal       = 1'b0;
      case (state_q)
         S_IDLE: begin
            ext_op  = 1'b0;
            state_d = S_FETCH;
         end
         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = SRCB_FOUR;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end
         end
         S_DECODE: begin
            // Branch target is precomputed here so BEQ_EX only has to compare.
            alu_src_b = SRCB_IMM_SH;
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_RTYPE_EX;
               OP_BEQ:       state_d = S_BEQ_EX;
               OP_ADDI:      state_d = S_ADDI_EX;
               OP_J:         state_d = S_JUMP;
`ifdef LOGIC_IMM_EN
               OP_ANDI, OP_ORI: state_d = S_LOGI_EX;
`endif
               default: begin
                  illegal = 1'b1;
                  state_d = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            if (mem_ready)
               state_d = S_MEMWB;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            retire     = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWR: begin
            mem_req   = 1'b1;
            mem_write = 1'b1;
            iord      = 1'b1;
            if (mem_ready) begin
               retire  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_RTYPE_EX: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_FUNCT;
            state_d   = S_RTYPE_WB;
         end
         S_RTYPE_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            retire    = 1'b1;
            state_d   = S_FETCH;
         end
         S_BEQ_EX: begin
            alu_src_a     = 1'b1;
            alu_op        = ALU_SUB;
            pc_src        = PC_SRC_ALUOUT;
            pc_write_cond = 1'b1;
            retire        = 1'b1;
            state_d       = S_FETCH;
         end
         S_ADDI_EX: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            state_d   = S_IMM_WB;
         end
         S_LOGI_EX: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALU_LOGIC;
            ext_op    = 1'b0;
            state_d   = S_IMM_WB;
         end
         S_IMM_WB: begin
            reg_write = 1'b1;
            retire    = 1'b1;
            state_d   = S_FETCH;
         end
         S_JUMP: begin
            pc_src   = PC_SRC_JUMP;
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
         end
         default: begin
            ext_op  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      retired_d = retired_q;
      if (retire)
         retired_d = retired_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
      end
   end

   mips_mem_timeout #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timeout (
      .clk       (clk),
      .rst_n     (rst_n),
      .mem_req   (mem_req),
      .mem_ready (mem_ready),
      .mem_err   (mem_err)
   );

   assign instr_retired = retired_q;
   assign state         = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: per-cycle control-word table plus timeout and reset sequences.
module tb_mips_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [5:0]  opcode = '0;
   logic        mem_ready = 1'b0;
   logic        mem_req, mem_write, iord, ir_write, pc_write, pc_write_cond;
   logic [1:0]  pc_src, alu_src_b, alu_op;
   logic        alu_src_a, ext_op, reg_dst, mem_to_reg, reg_write, illegal, mem_err;
   logic [31:0] instr_retired;
   logic [3:0]  state;

   always #5 clk = ~clk;

   mips_multicycle_ctrl #(.CNT_W(32), .MEM_TIMEOUT(255)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .opcode        (opcode),
      .mem_ready     (mem_ready),
      .mem_req       (mem_req),
      .mem_write     (mem_write),
      .iord          (iord),
      .ir_write      (ir_write),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .pc_src        (pc_src),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .ext_op        (ext_op),
      .reg_dst       (reg_dst),
      .mem_to_reg    (mem_to_reg),
      .reg_write     (reg_write),
      .illegal       (illegal),
      .mem_err       (mem_err),
      .instr_retired (instr_retired),
      .state         (state)
   );

   // Control word: mem_req mem_write iord ir_write pc_write pc_write_cond pc_src alu_src_a
   //               alu_src_b alu_op ext_op reg_dst mem_to_reg reg_write illegal
   logic [17:0] dut_cw;
   assign dut_cw = {mem_req, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_src,
                    alu_src_a, alu_src_b, alu_op, ext_op, reg_dst, mem_to_reg, reg_write, illegal};

   function automatic logic [17:0] cw(input logic mrq, mw, io, irw, pcw, pcwc, input logic [1:0] pcs,
                                      input logic asa, input logic [1:0] asb, aop,
                                      input logic ext, rd, m2r, rw, ill);
      return {mrq, mw, io, irw, pcw, pcwc, pcs, asa, asb, aop, ext, rd, m2r, rw, ill};
   endfunction

   typedef struct {
      logic [5:0]  op;
      logic        rdy;
      logic [3:0]  st;
      logic [17:0] cw;
      int          ret;
   } vec_t;

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
   localparam logic [5:0] ADDI = 6'b001000, JMP = 6'b000010, ORI = 6'b001101, BAD = 6'b111111;

   int n_run = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic apply(input logic [5:0] op, input logic rdy);
      @(negedge clk);
      opcode    = op;
      mem_ready = rdy;
      #1;
   endtask

   logic [17:0] c_fw, c_fd, c_dec, c_deci, c_madr, c_mrd, c_mwb, c_mwr;
   logic [17:0] c_rex, c_rwb, c_beq, c_addi, c_iwb, c_jmp, c_logi;
   vec_t vq[$];
   int   ro;

   initial begin
      c_fw   = cw(1,0,0,0,0,0,2'b00,0,2'b01,2'b00,1,0,0,0,0);
      c_fd   = cw(1,0,0,1,1,0,2'b00,0,2'b01,2'b00,1,0,0,0,0);
      c_dec  = cw(0,0,0,0,0,0,2'b00,0,2'b11,2'b00,1,0,0,0,0);
      c_deci = cw(0,0,0,0,0,0,2'b00,0,2'b11,2'b00,1,0,0,0,1);
      c_madr = cw(0,0,0,0,0,0,2'b00,1,2'b10,2'b00,1,0,0,0,0);
      c_mrd  = cw(1,0,1,0,0,0,2'b00,0,2'b00,2'b00,1,0,0,0,0);
      c_mwb  = cw(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,1,0,1,1,0);
      c_mwr  = cw(1,1,1,0,0,0,2'b00,0,2'b00,2'b00,1,0,0,0,0);
      c_rex  = cw(0,0,0,0,0,0,2'b00,1,2'b00,2'b10,1,0,0,0,0);
      c_rwb  = cw(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,1,1,0,1,0);
      c_beq  = cw(0,0,0,0,0,1,2'b01,1,2'b00,2'b01,1,0,0,0,0);
      c_addi = cw(0,0,0,0,0,0,2'b00,1,2'b10,2'b00,1,0,0,0,0);
      c_iwb  = cw(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,1,0,0,1,0);
      c_jmp  = cw(0,0,0,0,1,0,2'b10,0,2'b00,2'b00,1,0,0,0,0);
      c_logi = cw(0,0,0,0,0,0,2'b00,1,2'b10,2'b11,0,0,0,0,0);

      // lw with memory always ready
      vq.push_back('{LW, 1, 1, c_fd, 0});
      vq.push_back('{LW, 0, 2, c_dec, 0});
      vq.push_back('{LW, 1, 3, c_madr, 0});
      vq.push_back('{LW, 1, 4, c_mrd, 0});
      vq.push_back('{LW, 1, 5, c_mwb, 0});
      // fetch stalled three cycles, then an unknown opcode
      vq.push_back('{BAD, 0, 1, c_fw, 1});
      vq.push_back('{BAD, 0, 1, c_fw, 1});
      vq.push_back('{BAD, 0, 1, c_fw, 1});
      vq.push_back('{BAD, 1, 1, c_fd, 1});
      vq.push_back('{BAD, 1, 2, c_deci, 1});
      // addi, beq, j, R-type
      vq.push_back('{ADDI, 1, 1, c_fd, 1});
      vq.push_back('{ADDI, 1, 2, c_dec, 1});
      vq.push_back('{ADDI, 1, 10, c_addi, 1});
      vq.push_back('{ADDI, 0, 11, c_iwb, 1});
      vq.push_back('{BEQ, 1, 1, c_fd, 2});
      vq.push_back('{BEQ, 1, 2, c_dec, 2});
      vq.push_back('{BEQ, 1, 9, c_beq, 2});
      vq.push_back('{JMP, 1, 1, c_fd, 3});
      vq.push_back('{JMP, 1, 2, c_dec, 3});
      vq.push_back('{JMP, 0, 12, c_jmp, 3});
      vq.push_back('{RT, 1, 1, c_fd, 4});
      vq.push_back('{RT, 1, 2, c_dec, 4});
      vq.push_back('{RT, 1, 7, c_rex, 4});
      vq.push_back('{RT, 1, 8, c_rwb, 4});
      vq.push_back('{ORI, 1, 1, c_fd, 5});
`ifdef LOGIC_IMM_EN
      vq.push_back('{ORI, 1, 2, c_dec, 5});
      vq.push_back('{ORI, 1, 13, c_logi, 5});
      vq.push_back('{ORI, 1, 11, c_iwb, 5});
      ro = 6;
`else
      vq.push_back('{ORI, 1, 2, c_deci, 5});
      ro = 5;
`endif
      // sw completing immediately
      vq.push_back('{SW, 1, 1, c_fd, ro});
      vq.push_back('{SW, 1, 2, c_dec, ro});
      vq.push_back('{SW, 1, 3, c_madr, ro});
      vq.push_back('{SW, 1, 6, c_mwr, ro});

      // reset state, held and just released
      repeat (2) @(negedge clk);
      #1;
      chk("reset cw", 32'(dut_cw), 32'h0);
      chk("reset state", 32'(state), 32'd0);
      chk("reset retired", instr_retired, 32'd0);
      chk("reset mem_err", 32'(mem_err), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("idle state", 32'(state), 32'd0);
      chk("idle cw", 32'(dut_cw), 32'h0);

      foreach (vq[i]) begin
         apply(vq[i].op, vq[i].rdy);
         chk($sformatf("vec%0d state", i), 32'(state), 32'(vq[i].st));
         chk($sformatf("vec%0d cw", i), 32'(dut_cw), 32'(vq[i].cw));
         chk($sformatf("vec%0d retired", i), instr_retired, 32'(vq[i].ret));
         chk($sformatf("vec%0d mem_err", i), 32'(mem_err), 32'd0);
      end

      // sw stalled until the timeout limit
      apply(SW, 1);
      chk("to fetch", 32'(state), 32'd1);
      chk("to sw retired", instr_retired, 32'(ro + 1));
      apply(SW, 1);
      apply(SW, 0);
      chk("to memadr", 32'(state), 32'd3);
      for (int k = 1; k <= 255; k++) begin
         apply(SW, 0);
         if (k == 1)
            chk("to memwr cw", 32'(dut_cw), 32'(c_mwr));
         if (k == 254)
            chk("to err below limit", 32'(mem_err), 32'd0);
      end
      chk("to err at limit", 32'(mem_err), 32'd0);
      chk("to still memwr", 32'(state), 32'd6);
      apply(SW, 1);
      chk("to err set", 32'(mem_err), 32'd1);
      chk("to waiting memwr", 32'(state), 32'd6);
      apply(LW, 1);
      chk("to done state", 32'(state), 32'd1);
      chk("to done retired", instr_retired, 32'(ro + 2));
      chk("to err sticky", 32'(mem_err), 32'd1);

      // asynchronous reset in the middle of a load
      apply(LW, 1);
      apply(LW, 1);
      apply(LW, 0);
      chk("rst memrd state", 32'(state), 32'd4);
      chk("rst memrd cw", 32'(dut_cw), 32'(c_mrd));
      #2;
      rst_n = 1'b0;
      #1;
      chk("async rst cw", 32'(dut_cw), 32'h0);
      chk("async rst state", 32'(state), 32'd0);
      chk("async rst retired", instr_retired, 32'd0);
      chk("async rst mem_err", 32'(mem_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      apply(LW, 1);
      chk("restart fetch", 32'(state), 32'd1);
      chk("restart cw", 32'(dut_cw), 32'(c_fd));

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Main control FSM for the multi-cycle MIPS datapath, replacing the single-cycle combinational decoder. Sequences fetch/decode/execute/memory/writeback over a shared instruction/data memory, drives every datapath mux, write enable and the immediate-extension mode (ext_op) for the sign extender. Sits between the instruction register opcode field and the datapath. Also counts retired instructions.

Parameters:
CNT_W, 32, width of the retired-instruction counter
MEM_TIMEOUT, 255, max cycles waiting on mem_ready before flagging mem_err (8-bit internal counter)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  6  IR[31:26], valid from DECODE onward
mem_ready  input  1  memory completes current access this cycle
mem_req  output  1  memory access request, held until mem_ready
mem_write  output  1  write qualifier for mem_req
iord  output  1  0=PC address, 1=ALUOut address
ir_write  output  1  load IR
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if ALU zero
pc_src  output  2  00 ALU, 01 ALUOut, 10 jump target
alu_src_a  output  1  0=PC, 1=A
alu_src_b  output  2  00 B, 01 const 4, 10 ext imm, 11 ext imm<<2
alu_op  output  2  00 add, 01 sub, 10 funct, 11 logic-imm
ext_op  output  1  1=sign-extend imm16, 0=zero-extend
reg_dst  output  1  0=rt, 1=rd
mem_to_reg  output  1  0=ALUOut, 1=MDR
reg_write  output  1  register file write
illegal  output  1  one-cycle pulse on unknown opcode
mem_err  output  1  sticky, set on memory timeout
instr_retired  output  CNT_W  retired-instruction count
state  output  4  current state encoding, debug

Behaviour:
- Reset (rst_n low, async): state=IDLE, all outputs 0, instr_retired=0, mem_err=0, timeout counter=0.
- IDLE: all strobes 0; next cycle -> FETCH unconditionally.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. ir_write and pc_write asserted only in the cycle mem_ready=1 (Mealy qualification); then -> DECODE. Otherwise hold.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00, ext_op=1 (branch target precompute). Dispatch: 100011/101011 -> MEMADR; 000000 -> RTYPE_EX; 000100 -> BEQ_EX; 001000 -> ADDI_EX; 000010 -> JUMP; other -> FETCH with illegal=1 for that cycle, not retired.
- MEMADR: alu_src_a=1, alu_src_b=10, ext_op=1, alu_op=00; lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_req=1, iord=1; on mem_ready -> MEMWB. MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
- MEMWR: mem_req=1, mem_write=1, iord=1; on mem_ready -> FETCH.
- RTYPE_EX: alu_src_a=1, alu_src_b=00, alu_op=10 -> RTYPE_WB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- BEQ_EX: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_write_cond=1 -> FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, ext_op=1, alu_op=00 -> IMM_WB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
- JUMP: pc_src=10, pc_write=1 -> FETCH.
- ext_op=1 in every state except logic-immediate states (see feature); strobes not listed for a state are 0.
- Retire: instr_retired increments by 1 on the cycle leaving MEMWB, MEMWR(on mem_ready), RTYPE_WB, BEQ_EX, IMM_WB, JUMP; wraps 2^CNT_W-1 -> 0.
- Timeout: counter clears on entering any mem_req state, increments each waiting cycle; reaching MEM_TIMEOUT sets mem_err (sticky until reset), FSM continues to wait. mem_ready in the same cycle as the limit: access completes, mem_err still set.
- mem_ready outside mem_req states is ignored.
- Reset mid-instruction: immediate return to IDLE, no partial write strobes.

Optional Feature:
LOGIC_IMM_EN: defined -> opcodes 001100 (andi) and 001101 (ori) dispatch to LOGI_EX (alu_src_a=1, alu_src_b=10, ext_op=0, alu_op=11) then IMM_WB. Undefined -> both take the illegal path.

Decomposition:
- Package mips_ctrl_pkg: state enum (4-bit), opcode constants, alu_op/pc_src/alu_src_b encodings.
- Sub-module mips_mem_timeout: timeout counter + sticky mem_err.

Test Plan:
- Reset release, mem_ready tied 1, lw (100011) -> IDLE,FETCH,DECODE,MEMADR,MEMRD,MEMWB; reg_write+mem_to_reg in MEMWB; instr_retired=1.
- FETCH with mem_ready low 3 cycles -> ir_write/pc_write only on 4th cycle; state stays FETCH.
- Opcode 111111 -> illegal pulses in DECODE, back to FETCH, instr_retired unchanged.
- addi then beq then j -> ext_op=1 in ADDI_EX; pc_write_cond only in BEQ_EX; pc_src=10 in JUMP; counter=3.
- mem_ready held low 255 cycles in MEMWR -> mem_err=1 and stays after completion; rst_n low mid-MEMRD -> all outputs 0 asynchronously.
- With LOGIC_IMM_EN, ori (001101) -> LOGI_EX with ext_op=0, alu_op=11; without macro -> illegal pulse.
